// File: rtl/hazard_pkg.sv
// Shared types and widths for the 5-stage pipeline hazard controller.
package hazard_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int PERF_W     = 32;

  typedef enum logic {
    HZ_RUN     = 1'b0,
    HZ_MD_BUSY = 1'b1
  } hz_state_e;

  // A load in EX feeds a register the ID instruction reads; x0 never creates a dependency.
  function automatic logic load_use_hit(
    input logic                  ex_is_load,
    input logic [REG_ADDR_W-1:0] ex_rd,
    input logic [REG_ADDR_W-1:0] id_rs1,
    input logic [REG_ADDR_W-1:0] id_rs2,
    input logic                  id_use_rs1,
    input logic                  id_use_rs2
  );
    return ex_is_load && (ex_rd != '0) &&
           ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating event counters for stall cycles and front-end flushes.
// Present only when HAZARD_PERF_EN is defined.
`ifdef HAZARD_PERF_EN
module hazard_perf_cnt
  import hazard_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_evt_i,
  input  logic              flush_evt_i,
  output logic [PERF_W-1:0] stall_cnt_o,
  output logic [PERF_W-1:0] flush_cnt_o
);

  logic [PERF_W-1:0] stall_cnt_q;
  logic [PERF_W-1:0] flush_cnt_q;

  // Counters stick at all-ones rather than wrapping, so long runs never read as short ones.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_evt_i && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_evt_i && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule
`endif

// File: rtl/hazard_ctrl.sv
// Stall/flush controller: data-memory wait, mul/div occupancy, EX redirect, load-use interlock.
// Define HAZARD_PERF_EN to add the perf_stall_cyc / perf_flush_evt counter outputs.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_is_load,
  input  logic                  ex_redirect,
  input  logic                  ex_md_start,
  input  logic                  dmem_req,
  input  logic                  dmem_ready,
  output logic                  pc_stall,
  output logic                  if_id_stall,
  output logic                  if_id_flush,
  output logic                  id_ex_stall,
  output logic                  id_ex_flush,
  output logic                  ex_mem_stall,
  output logic                  ex_mem_flush,
  output logic                  mem_wb_flush,
  output logic                  md_freeze,
  output logic                  md_done
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0]     perf_stall_cyc,
  output logic [PERF_W-1:0]     perf_flush_evt
`endif
);

  localparam bit               MD_MULTI = (MD_LAT > 1);
  localparam logic [CNT_W-1:0] MD_INIT  = MD_MULTI ? CNT_W'(MD_LAT - 2) : '0;

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic             mem_wait;
  logic             load_use;
  logic             md_hold;

  assign mem_wait = dmem_req && !dmem_ready;
  assign load_use = load_use_hit(ex_is_load, ex_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2);

  always_comb begin
    // NOTE: every output and next-state gets a default first, so no path can infer a latch.
    state_d      = state_q;
    md_cnt_d     = md_cnt_q;
    md_hold      = 1'b0;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    md_freeze    = 1'b0;
    md_done      = 1'b0;

    if (!rst) begin
      state_d  = HZ_RUN;
      md_cnt_d = '0;
    end else if (mem_wait) begin
      // Whole front of the pipe freezes; EX re-presents its redirect/load-use next cycle.
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      mem_wb_flush = 1'b1;
      md_freeze    = 1'b1;
    end else begin
      if (state_q == HZ_MD_BUSY) begin
        if (md_cnt_q == '0) begin
          md_done = 1'b1;
          state_d = HZ_RUN;
        end else begin
          md_hold  = 1'b1;
          md_cnt_d = md_cnt_q - 1'b1;
        end
      end else if (ex_md_start) begin
        if (MD_MULTI) begin
          md_hold  = 1'b1;
          state_d  = HZ_MD_BUSY;
          md_cnt_d = MD_INIT;
        end else begin
          md_done = 1'b1;
        end
      end

      if (md_hold) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_flush = 1'b1;
      end else if (ex_redirect) begin
        // PC is left free so it loads the redirect target this edge.
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= HZ_RUN;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

`ifdef HAZARD_PERF_EN
  hazard_perf_cnt u_perf (
    .clk         (clk),
    .rst         (rst),
    .stall_evt_i (pc_stall),
    .flush_evt_i (if_id_flush),
    .stall_cnt_o (perf_stall_cyc),
    .flush_cnt_o (perf_flush_evt)
  );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: per-cycle reference model plus literal per-step expectations.
module tb_hazard_ctrl;

  localparam int MD_LAT = 4;
  localparam int CNT_W  = 3;

  // Output vector order: pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
  // ex_mem_stall, ex_mem_flush, mem_wb_flush, md_freeze, md_done
  localparam logic [9:0] O_NONE = 10'b0000000000;
  localparam logic [9:0] O_LU   = 10'b1100100000;
  localparam logic [9:0] O_RD   = 10'b0010100000;
  localparam logic [9:0] O_MDS  = 10'b1101001000;
  localparam logic [9:0] O_MW   = 10'b1101010110;
  localparam logic [9:0] O_DONE = 10'b0000000001;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       ld;
    logic       redir;
    logic       md;
    logic       req;
    logic       rdy;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_is_load, ex_redirect, ex_md_start;
  logic       dmem_req, dmem_ready;
  logic       pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic       ex_mem_stall, ex_mem_flush, mem_wb_flush, md_freeze, md_done;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cyc, perf_flush_evt;
`endif

  hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .ex_rd        (ex_rd),
    .ex_is_load   (ex_is_load),
    .ex_redirect  (ex_redirect),
    .ex_md_start  (ex_md_start),
    .dmem_req     (dmem_req),
    .dmem_ready   (dmem_ready),
    .pc_stall     (pc_stall),
    .if_id_stall  (if_id_stall),
    .if_id_flush  (if_id_flush),
    .id_ex_stall  (id_ex_stall),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_stall (ex_mem_stall),
    .ex_mem_flush (ex_mem_flush),
    .mem_wb_flush (mem_wb_flush),
    .md_freeze    (md_freeze),
    .md_done      (md_done)
`ifdef HAZARD_PERF_EN
    ,
    .perf_stall_cyc (perf_stall_cyc),
    .perf_flush_evt (perf_flush_evt)
`endif
  );

  always #5 clk = ~clk;

  wire [9:0] outs = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                     ex_mem_stall, ex_mem_flush, mem_wb_flush, md_freeze, md_done};

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t v(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic u1, input logic u2, input logic [4:0] rd,
                             input logic ld, input logic redir, input logic md,
                             input logic req, input logic rdy);
    vec_t t;
    t = '{rst: r, rs1: rs1, rs2: rs2, u1: u1, u2: u2, rd: rd, ld: ld,
          redir: redir, md: md, req: req, rdy: rdy};
    return t;
  endfunction

  task automatic apply(input vec_t t);
    rst         = t.rst;
    id_rs1      = t.rs1;
    id_rs2      = t.rs2;
    id_use_rs1  = t.u1;
    id_use_rs2  = t.u2;
    ex_rd       = t.rd;
    ex_is_load  = t.ld;
    ex_redirect = t.redir;
    ex_md_start = t.md;
    dmem_req    = t.req;
    dmem_ready  = t.rdy;
  endtask

  // One clock cycle of stimulus, then a literal check of that cycle's outputs.
  task automatic step(input string name, input vec_t t, input logic [9:0] exp);
    @(posedge clk);
    #1;
    apply(t);
    @(negedge clk);
    #1;
    check(name, {22'd0, outs}, {22'd0, exp});
  endtask

  // Reference model: md_age counts EX cycles already spent by the mul/div in EX (-1 = none).
  // A mul/div finishes on its MD_LAT-th non-waiting EX cycle; memory waits do not age it.
  int md_age = -1;
  always @(negedge clk) begin
    logic [9:0] e;
    logic       free;
    logic       lu;
    int         a;
    e    = O_NONE;
    free = 1'b1;
    lu   = ex_is_load && (ex_rd != 5'd0) &&
           ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (rst !== 1'b1) begin
      md_age = -1;
    end else if (dmem_req && !dmem_ready) begin
      e = O_MW;
    end else begin
      if (md_age >= 0 || ex_md_start) begin
        a = (md_age >= 0) ? md_age : 0;
        if (a == MD_LAT - 1) begin
          e      = O_DONE;
          md_age = -1;
        end else begin
          e      = O_MDS;
          md_age = a + 1;
          free   = 1'b0;
        end
      end
      if (free) begin
        if (ex_redirect) e = e | O_RD;
        else if (lu)     e = e | O_LU;
      end
    end
    check("model", {22'd0, outs}, {22'd0, e});
  end

  initial begin
    vec_t idle;
    vec_t lu1;
    idle = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    lu1  = v(1, 5, 0, 1, 0, 5, 1, 0, 0, 0, 0);

    apply(v(0, 5, 0, 1, 0, 5, 1, 1, 1, 1, 0));
    step("reset_forced_zero", v(0, 5, 0, 1, 0, 5, 1, 1, 1, 1, 0), O_NONE);
    step("reset_hold",        v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), O_NONE);
`ifdef HAZARD_PERF_EN
    check("perf_stall_reset", perf_stall_cyc, 32'd0);
    check("perf_flush_reset", perf_flush_evt, 32'd0);
`endif
    step("idle",              idle, O_NONE);

    step("load_use_rs1",      lu1, O_LU);
    step("load_use_released", idle, O_NONE);
    step("load_use_rs2",      v(1, 0, 7, 0, 1, 7, 1, 0, 0, 0, 0), O_LU);
    step("load_use_rd0",      v(1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0), O_NONE);
    step("load_use_no_use",   v(1, 5, 0, 0, 0, 5, 1, 0, 0, 0, 0), O_NONE);
    step("load_use_not_load", v(1, 5, 0, 1, 0, 5, 0, 0, 0, 0, 0), O_NONE);
    step("redirect_over_lu",  v(1, 5, 0, 1, 0, 5, 1, 1, 0, 0, 0), O_RD);
    step("redirect_only",     v(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), O_RD);
    step("dmem_ready_no_wait", v(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), O_NONE);

    // Mul/div with no memory wait: stalls t..t+2, done at t+3.
    step("md_t0", v(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), O_MDS);
    step("md_t1", v(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), O_MDS);
    step("md_t2", v(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), O_MDS);
    step("md_t3_done", v(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), O_DONE);
    step("md_after",   idle, O_NONE);

    // Mul/div interrupted by a 3-cycle memory wait: done moves to t+6.
    step("mdw_t0", v(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), O_MDS);
    step("mdw_t1_wait", v(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), O_MW);
    step("mdw_t2_wait", v(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), O_MW);
    step("mdw_t3_wait", v(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), O_MW);
    step("mdw_t4", v(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), O_MDS);
    step("mdw_t5", v(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), O_MDS);
    step("mdw_t6_done", v(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), O_DONE);
    step("mdw_after", idle, O_NONE);

    // Memory wait defers a redirect; it is honoured once the wait clears.
    step("wait_over_redirect", v(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0), O_MW);
    step("redirect_after_wait", v(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), O_RD);

    // Reset in the middle of MD_BUSY: RUN afterwards, no md_done.
    step("mdr_t0", v(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), O_MDS);
    step("mdr_t1", v(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), O_MDS);
    step("mdr_reset", v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), O_NONE);
    step("mdr_run_no_done", idle, O_NONE);
    step("mdr_lu_after", lu1, O_LU);
`ifdef HAZARD_PERF_EN
    step("perf_reset", v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), O_NONE);
    @(posedge clk);
    #1;
    check("perf_stall_cleared", perf_stall_cyc, 32'd0);
    check("perf_flush_cleared", perf_flush_evt, 32'd0);
`endif
    step("final_idle", idle, O_NONE);

    @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
